// File: rtl/cg_pkg.sv
// Shared types and constants for the CG phase sequencer.
package cg_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_MXV, S_VXV1, S_UPD, S_VXV2, S_PUPD, S_ITER_END, S_DONE, S_ERR
  } state_t;

  localparam int NUM_PH  = 6;
  localparam int PH_MXV  = 0;
  localparam int PH_VXV1 = 1;
  localparam int PH_XUPD = 2;
  localparam int PH_RUPD = 3;
  localparam int PH_VXV2 = 4;
  localparam int PH_PUPD = 5;

  localparam int NO_OF_ITERATION_DEF = 20;

  function automatic logic in_phase(state_t s);
    return s inside {S_MXV, S_VXV1, S_UPD, S_VXV2, S_PUPD};
  endfunction

endpackage

// File: rtl/cg_phase_watchdog.sv
// Per-phase cycle counter; expire rises once LIMIT-1 cycles have passed since clear.
module cg_phase_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);
  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)                                    cnt <= '0;
    else if (clear)                                cnt <= '0;
    else if (enable && cnt != CW'(LIMIT - 1))      cnt <= cnt + CW'(1);
  end

  assign expire = enable && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/cg_phase_sequencer.sv
// CG iteration scheduler: launches each phase, waits for done, counts iterations.
// Optional per-phase watchdog compiled in with CG_PHASE_WATCHDOG_EN.
module cg_phase_sequencer
  import cg_pkg::*;
#(
  parameter int NO_OF_ITERATION = NO_OF_ITERATION_DEF,
  parameter int ITER_W          = 11,
  parameter int PHASE_TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              converged,
  input  logic [5:0]        phase_done,
  output logic [5:0]        phase_go,
  output logic              finish_alu,
  output logic              finish_all,
  output logic              halt,
  output logic              busy,
  output logic [ITER_W-1:0] iteration_count,
  output logic              err
);

  state_t            state, state_n;
  logic [5:0]        go_n, valid, live;
  logic              fa_n, fall_n, halt_n, busy_n, err_n;
  logic [ITER_W-1:0] cnt_n;
  logic              conv_q, conv_n;
  logic              x_q, r_q, x_n, r_n, x_set, r_set;

`ifdef CG_PHASE_WATCHDOG_EN
  logic wd_expire;

  cg_phase_watchdog #(.LIMIT(PHASE_TIMEOUT)) u_wd (
    .clk    (clk),
    .reset  (reset),
    .enable (in_phase(state)),
    .clear  (|go_n),
    .expire (wd_expire)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      phase_go        <= '0;
      finish_alu      <= 1'b0;
      finish_all      <= 1'b0;
      halt            <= 1'b0;
      busy            <= 1'b0;
      iteration_count <= '0;
      err             <= 1'b0;
      conv_q          <= 1'b0;
      x_q             <= 1'b0;
      r_q             <= 1'b0;
    end else begin
      state           <= state_n;
      phase_go        <= go_n;
      finish_alu      <= fa_n;
      finish_all      <= fall_n;
      halt            <= halt_n;
      busy            <= busy_n;
      iteration_count <= cnt_n;
      err             <= err_n;
      conv_q          <= conv_n;
      x_q             <= x_n;
      r_q             <= r_n;
    end
  end

  always_comb begin
    state_n = state;
    go_n    = '0;
    fa_n    = 1'b0;
    fall_n  = 1'b0;
    cnt_n   = iteration_count;
    conv_n  = conv_q;
    x_n     = x_q;
    r_n     = r_q;
    valid   = '0;
    x_set   = 1'b0;
    r_set   = 1'b0;

    // Done bits the current state may consume; none during the go (entry) cycle.
    case (state)
      S_MXV:  valid[PH_MXV]  = 1'b1;
      S_VXV1: valid[PH_VXV1] = 1'b1;
      S_UPD:  begin valid[PH_XUPD] = 1'b1; valid[PH_RUPD] = 1'b1; end
      S_VXV2: valid[PH_VXV2] = 1'b1;
      S_PUPD: valid[PH_PUPD] = 1'b1;
      default: valid = '0;
    endcase
    if (|phase_go) valid = '0;
    live = phase_done & valid;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n        = S_MXV;
          go_n[PH_MXV]   = 1'b1;
          cnt_n          = '0;
          conv_n         = 1'b0;
        end
      end
      S_MXV: if (live[PH_MXV]) begin
        state_n       = S_VXV1;
        go_n[PH_VXV1] = 1'b1;
      end
      S_VXV1: if (live[PH_VXV1]) begin
        state_n       = S_UPD;
        go_n[PH_XUPD] = 1'b1;
        go_n[PH_RUPD] = 1'b1;
      end
      S_UPD: begin
        x_set = x_q | live[PH_XUPD];
        r_set = r_q | live[PH_RUPD];
        if (x_set && r_set) begin
          state_n       = S_VXV2;
          go_n[PH_VXV2] = 1'b1;
          x_n           = 1'b0;
          r_n           = 1'b0;
        end else begin
          x_n = x_set;
          r_n = r_set;
        end
      end
      S_VXV2: if (live[PH_VXV2]) begin
        state_n       = S_PUPD;
        go_n[PH_PUPD] = 1'b1;
        conv_n        = converged;
      end
      S_PUPD: if (live[PH_PUPD]) begin
        state_n = S_ITER_END;
        fa_n    = 1'b1;
        if (iteration_count != '1) cnt_n = iteration_count + ITER_W'(1);
      end
      S_ITER_END: begin
        // Count already holds the just-completed iteration here.
        if (conv_q || iteration_count == ITER_W'(NO_OF_ITERATION)) begin
          state_n = S_DONE;
          fall_n  = 1'b1;
        end else begin
          state_n      = S_MXV;
          go_n[PH_MXV] = 1'b1;
        end
      end
      default: state_n = state;
    endcase

`ifdef CG_PHASE_WATCHDOG_EN
    if (wd_expire && in_phase(state) && state_n == state) begin
      state_n = S_ERR;
      go_n    = '0;
      x_n     = 1'b0;
      r_n     = 1'b0;
    end
`endif

    err_n  = err | (|(phase_done & ~valid)) | (state_n == S_ERR);
    busy_n = in_phase(state_n) || state_n == S_ITER_END;
    halt_n = (state_n == S_DONE) || (state_n == S_ERR);
  end

endmodule

// File: tb/tb_cg_phase_sequencer.sv
// Directed bench for cg_phase_sequencer: cycle table plus multi-cycle solve sequences.
module tb_cg_phase_sequencer;
  localparam int ITER_W = 11;
  localparam int NIT    = 3;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              converged = 1'b0;
  logic [5:0]        phase_done = '0;
  logic [5:0]        phase_go;
  logic              finish_alu, finish_all, halt, busy, err;
  logic [ITER_W-1:0] iteration_count;

  always #5 clk = ~clk;

  cg_phase_sequencer #(.NO_OF_ITERATION(NIT), .ITER_W(ITER_W), .PHASE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .converged(converged),
    .phase_done(phase_done), .phase_go(phase_go), .finish_alu(finish_alu),
    .finish_all(finish_all), .halt(halt), .busy(busy),
    .iteration_count(iteration_count), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        rst, st, cv;
    logic [5:0]  dn;
    logic [5:0]  go;
    logic        fa, fl, ht, bz, er;
    logic [10:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic st, logic cv, logic [5:0] dn, logic [5:0] go,
                              logic fa, logic fl, logic ht, logic bz, logic er, logic [10:0] cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.cv = cv; v.dn = dn; v.go = go;
    v.fa = fa; v.fl = fl; v.ht = ht; v.bz = bz; v.er = er; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {10'b0, phase_go, finish_alu, finish_all, halt, busy, err, iteration_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic c, input logic [5:0] d);
    @(negedge clk);
    reset = r; start = s; converged = c; phase_done = d;
    @(posedge clk); #1;
  endtask

  function automatic int dly(int b, int iter, int dx1, int dr1, int dx, int dr);
    if (b == 2) return (iter == 1) ? dx1 : dx;
    if (b == 3) return (iter == 1) ? dr1 : dr;
    return 5;
  endfunction

  // Reset, start, then answer every go pulse with its done after a per-phase delay.
  task automatic drive_solve(input int conv_iter, input int dx1, input int dr1, input int dx,
                             input int dr, input bit stray, output int n_alu, output int n_all,
                             output int order_bad, output int gap_bad, output int first_cnt);
    int t[6];
    int ts, exp_idx, upd_edge, edge_n;
    bit prev_fa;
    logic [5:0] order [5];
    order[0] = 6'h01; order[1] = 6'h02; order[2] = 6'h0C; order[3] = 6'h10; order[4] = 6'h20;
    for (int b = 0; b < 6; b++) t[b] = 0;
    ts = 0; exp_idx = 0; upd_edge = -1; edge_n = 0; prev_fa = 1'b0;
    n_alu = 0; n_all = 0; order_bad = 0; gap_bad = 0; first_cnt = -1;
    step(1'b0, 1'b0, 1'b0, 6'h00);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; phase_done = '0; converged = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      edge_n++;
      if (prev_fa && ((phase_go == 6'h01) == finish_all)) order_bad++;
      prev_fa = finish_alu;
      if (finish_alu) begin
        n_alu++;
        if (n_alu == 1) first_cnt = int'(iteration_count);
      end
      if (finish_all) n_all++;
      if (phase_go != '0) begin
        if (phase_go != order[exp_idx]) order_bad++;
        exp_idx = (exp_idx + 1) % 5;
        if (phase_go[4] && upd_edge != edge_n) gap_bad++;
        if (phase_go[0] && stray && n_alu == 0) ts = 2;
        for (int b = 0; b < 6; b++)
          if (phase_go[b]) t[b] = dly(b, n_alu + 1, dx1, dr1, dx, dr);
      end
      if (halt) break;
      @(negedge clk);
      start = 1'b0; phase_done = '0; converged = 1'b0;
      for (int b = 0; b < 6; b++)
        if (t[b] > 0) begin
          t[b]--;
          if (t[b] == 0) phase_done[b] = 1'b1;
        end
      if (phase_done[2] || phase_done[3]) upd_edge = edge_n + 1;
      if (phase_done[4] && n_alu + 1 == conv_iter) converged = 1'b1;
      if (ts > 0) begin
        ts--;
        if (ts == 0) phase_done[4] = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0; phase_done = '0; converged = 1'b0;
  endtask

  vec_t tbl [18];
  int   a, l, ob, gb, fc;

  initial begin
    tbl[0]  = mk(0,0,0,6'h00, 6'h00,0,0,0,0,0,0);
    tbl[1]  = mk(1,0,0,6'h00, 6'h00,0,0,0,0,0,0);
    tbl[2]  = mk(1,1,0,6'h00, 6'h01,0,0,0,1,0,0);
    tbl[3]  = mk(1,0,0,6'h01, 6'h00,0,0,0,1,1,0);
    tbl[4]  = mk(1,0,0,6'h01, 6'h02,0,0,0,1,1,0);
    tbl[5]  = mk(1,0,0,6'h00, 6'h00,0,0,0,1,1,0);
    tbl[6]  = mk(1,0,0,6'h02, 6'h0C,0,0,0,1,1,0);
    tbl[7]  = mk(1,0,0,6'h00, 6'h00,0,0,0,1,1,0);
    tbl[8]  = mk(1,0,0,6'h08, 6'h00,0,0,0,1,1,0);
    tbl[9]  = mk(1,0,0,6'h04, 6'h10,0,0,0,1,1,0);
    tbl[10] = mk(1,0,0,6'h00, 6'h00,0,0,0,1,1,0);
    tbl[11] = mk(1,0,1,6'h10, 6'h20,0,0,0,1,1,0);
    tbl[12] = mk(1,0,0,6'h00, 6'h00,0,0,0,1,1,0);
    tbl[13] = mk(1,0,0,6'h20, 6'h00,1,0,0,1,1,1);
    tbl[14] = mk(1,0,0,6'h00, 6'h00,0,1,1,0,1,1);
    tbl[15] = mk(1,0,0,6'h00, 6'h00,0,0,1,0,1,1);
    tbl[16] = mk(1,1,0,6'h00, 6'h01,0,0,0,1,1,0);
    tbl[17] = mk(0,0,0,6'h00, 6'h00,0,0,0,0,0,0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].cv, tbl[i].dn);
      check($sformatf("vec%0d", i), outs(),
            {10'b0, tbl[i].go, tbl[i].fa, tbl[i].fl, tbl[i].ht, tbl[i].bz, tbl[i].er, tbl[i].cnt});
    end

    // Normal solve: runs to the iteration limit.
    drive_solve(0, 5, 5, 5, 5, 1'b0, a, l, ob, gb, fc);
    check("norm_finish_alu", a, NIT);
    check("norm_finish_all", l, 1);
    check("norm_count", iteration_count, NIT);
    check("norm_halt_busy_err", {halt, busy, err}, 3'b100);
    check("norm_order", ob, 0);
    check("norm_first_count", fc, 1);

    // Early exit on convergence in iteration 2.
    drive_solve(2, 5, 5, 5, 5, 1'b0, a, l, ob, gb, fc);
    check("early_finish_alu", a, 2);
    check("early_finish_all", l, 1);
    check("early_count", iteration_count, 2);
    check("early_halt_err", {halt, err}, 2'b10);
    check("early_order", ob, 0);

    // UPD: r done 2 cycles before x, then simultaneous.
    drive_solve(0, 5, 3, 4, 4, 1'b0, a, l, ob, gb, fc);
    check("upd_gap", gb, 0);
    check("upd_finish_alu", a, NIT);
    check("upd_err", err, 0);

    // Stray VXV2 done during MXV: flags err, solve otherwise unaffected.
    drive_solve(0, 5, 5, 5, 5, 1'b1, a, l, ob, gb, fc);
    check("stray_err", err, 1);
    check("stray_order", ob, 0);
    check("stray_finish_alu", a, NIT);
    check("stray_count_halt", {halt, 21'(iteration_count)}, {1'b1, 21'(NIT)});

    // Reset in the middle of UPD, then restart.
    step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    check("rst_go_mxv", phase_go, 6'h01);
    step(1'b1, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b0, 1'b0, 6'h01);
    step(1'b1, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b0, 1'b0, 6'h02);
    check("rst_go_upd", phase_go, 6'h0C);
    step(1'b1, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b0, 1'b0, 6'h04);
    step(1'b0, 1'b0, 1'b0, 6'h00);
    check("rst_mid_upd_outs", outs(), 32'h0);
    step(1'b1, 1'b0, 1'b0, 6'h00);
    check("rst_idle_outs", outs(), 32'h0);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    check("rst_restart_outs", outs(), {10'b0, 6'h01, 5'b00010, 11'd0});

    // VXV1 done withheld.
    step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    step(1'b1, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b0, 1'b0, 6'h01);
    check("wd_go_vxv1", phase_go, 6'h02);
`ifdef CG_PHASE_WATCHDOG_EN
    for (int k = 0; k < TO - 1; k++) step(1'b1, 1'b0, 1'b0, 6'h00);
    check("wd_before_expire", {err, halt, busy}, 3'b001);
    step(1'b1, 1'b0, 1'b0, 6'h00);
    check("wd_expired", {err, halt, busy}, 3'b110);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    check("wd_err_sticky", {phase_go, err, halt, busy}, {6'h00, 3'b110});
`else
    for (int k = 0; k < 3 * TO; k++) step(1'b1, 1'b0, 1'b0, 6'h00);
    check("nowd_still_waiting", {phase_go, err, halt, busy}, {6'h00, 3'b001});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cg_phase_sequencer.md
# cg_phase_sequencer

Iteration-level scheduler for the conjugate-gradient datapath. Launches each phase of a CG iteration (A·p, p·Ap, x/r update, r·r, p update) in order via one-cycle go pulses, waits for each phase's done, and issues the per-iteration `finish_alu` and final `finish_all` strobes consumed by `control_unit`. Sits above `control_unit` and the ALU clusters, and owns the iteration count and the halt decision.

## Interface
Parameters:
- `NO_OF_ITERATION`, 20: maximum CG iterations before forced halt.
- `ITER_W`, 11: width of `iteration_count`.
- `PHASE_TIMEOUT`, 4096: watchdog limit in cycles per phase (used only with watchdog compiled in).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on `clk`).
- `start`  in  1  level; sampled only in IDLE/DONE.
- `converged`  in  1  r·r below tolerance; valid when `phase_done[4]` is high.
- `phase_done`  in  6  per-phase done pulses: [0] MXV, [1] VXV1, [2] XUPD, [3] RUPD, [4] VXV2, [5] PUPD.
- `phase_go`  out  6  one-cycle launch pulses, same bit map.
- `finish_alu`  out  1  one-cycle end-of-iteration strobe.
- `finish_all`  out  1  one-cycle end-of-solve strobe.
- `halt`  out  1  solve ended (normal or error).
- `busy`  out  1  high in any phase or ITER_END state.
- `iteration_count`  out  ITER_W  completed iterations.
- `err`  out  1  sticky error flag.

## Operation
- States: IDLE, MXV, VXV1, UPD, VXV2, PUPD, ITER_END, DONE, ERR.
- IDLE/DONE + `start` → MXV; `iteration_count` cleared, `halt` cleared.
- On entry to each phase state, the matching `phase_go` bit(s) pulse for exactly the entry cycle. UPD pulses bits [2] and [3] together.
- MXV→VXV1 on `phase_done[0]`; VXV1→UPD on `[1]`; VXV2→PUPD on `[4]`; PUPD→ITER_END on `[5]`.
- UPD: x and r updates run concurrently. Two sticky flags latch `[2]` and `[3]`. Exit to VXV2 in the cycle both are set (either flag or live bit). Flags clear on exit.
- VXV2: `converged` is captured into `conv_q` in the cycle `phase_done[4]` is high.
- ITER_END (one cycle): `finish_alu`=1, `iteration_count`+=1.
  - If `conv_q` or the new count equals `NO_OF_ITERATION` → DONE, with `finish_all`=1 in the DONE entry cycle.
  - Else → MXV.
- DONE: `halt`=1 and held until `start`.
- A `phase_done` bit not belonging to the current state, or any done in IDLE/DONE/ITER_END, sets `err` (sticky until reset). The bit is otherwise ignored and the state is unchanged.
- `iteration_count` saturates at its all-ones value and never wraps.

## Timing
- Reset values: `phase_go`=0, `finish_alu`=0, `finish_all`=0, `halt`=0, `busy`=0, `iteration_count`=0, `err`=0, state IDLE.
- `reset` low mid-phase: next edge returns to IDLE with all outputs at reset values. No go or finish pulses are issued in that cycle.
- All outputs are registered.
- `start` at edge N → `phase_go[0]` high during cycle N+1.
- `phase_done` is honoured no earlier than the cycle after the go pulse. Done in the same cycle as go counts as a protocol error.
- Done at edge N → next phase's go during cycle N+1. Per-phase overhead is 1 cycle.
- Last `phase_done[5]` at edge N → `finish_alu` in N+1 → `phase_go[0]` or `finish_all` in N+2.
- `start` while `busy` is ignored.

## Configuration
- Macro: `CG_PHASE_WATCHDOG_EN`.
- Defined: a per-phase cycle counter clears on every go pulse. If it reaches `PHASE_TIMEOUT`-1 without the awaited done, the FSM moves to ERR, sets `err`=1, `halt`=1, `busy`=0. ERR exits only on reset.
- Undefined: no counter and no ERR entry path. The FSM waits indefinitely, and `err` reports protocol errors only.

## Structure
- Shared package `cg_pkg`: state enum, phase index constants (PH_MXV…PH_PUPD), `NO_OF_ITERATION` default.
- One sub-module, `cg_phase_watchdog` (counter plus compare, enable/clear/expire), instantiated only under the macro.

## Test plan
- Normal solve: `NO_OF_ITERATION`=3, `converged`=0, each done 5 cycles after go → 3 `finish_alu` pulses, 1 `finish_all`, `iteration_count`=3, `halt`=1.
- Early exit: `converged`=1 with `phase_done[4]` in iteration 2 → `finish_all` after the 2nd `finish_alu`, `iteration_count`=2.
- UPD ordering: `phase_done[3]` 2 cycles before `[2]`, then both in the same cycle on the next iteration → VXV2 go one cycle after the later/common done in both cases.
- Protocol error: `phase_done[4]` pulsed during MXV → `err`=1, state stays MXV, solve completes normally.
- Reset mid-UPD: drive `reset`=0 for one edge → all outputs 0, IDLE. A subsequent `start` restarts at `iteration_count`=0.
- With `CG_PHASE_WATCHDOG_EN`, `PHASE_TIMEOUT`=16, VXV1 done withheld → `err`=1, `halt`=1 exactly 16 cycles after `phase_go[1]`.
